jedro_1_dmem_arbiter: RTL and testbench
=======================================

// Module: jedro_1_dmem_arbiter
// PURPOSE
//  Shares the single-port byte-write data RAM between two requesters: the jedro_1 core LSU (port 0, core_*)
//  and a debug/loader master (port 1, dbg_*). Sits between jedro_1_top data port and bytewrite_ram_wrap.
//  One access per cycle. Arbitration is round-robin with a bounded back-to-back burst. The read latency seen
//  by each requester is the RAM's fixed 1 cycle.
// PARAMETERS
//  DATA_WIDTH  32  data word width; byte enables are DATA_WIDTH/8
//  ADDR_WIDTH  32  byte address width
//  MAX_BURST   4   max consecutive grants to one port while the other is requesting (>=1)
// PORTS
//  clk_i        in   1     clock
//  rstn_i       in   1     asynchronous active-low reset
//  core_req_i   in   1     core access request
//  core_we_i    in   BE    core byte write enables (0 = read)
//  core_addr_i  in   AW    core address
//  core_wdata_i in   DW    core write data
//  core_gnt_o   out  1     core request accepted this cycle (combinational)
//  core_rvalid_o out 1     core response, 1 cycle after gnt
//  core_rdata_o out  DW    core read data, valid with rvalid on reads
//  dbg_*        ---  ---   same set for port 1 (dbg_req_i ... dbg_rdata_o)
//  ram_en_o     out  1     RAM access strobe
//  ram_we_o     out  BE    RAM byte write enables
//  ram_addr_o   out  AW    RAM address
//  ram_wdata_o  out  DW    RAM write data
//  ram_rdata_i  in   DW    RAM read data, 1 cycle after ram_en_o
// BEHAVIOUR
//  - Reset values: gnt, rvalid and ram_en = 0; rdata = 0; last_owner = CORE; burst_cnt = 0; resp_owner = NONE.
//  - Grant (combinational, same cycle): only one port requests -> grant it. Both request -> grant last_owner
//    if burst_cnt < MAX_BURST, otherwise grant the other port. No request -> no grant, ram_en_o = 0.
//  - The granted port's we/addr/wdata drive ram_*_o in the grant cycle. When there is no grant, ram_we_o = 0.
//  - Registered state updates on each grant:
//    - resp_owner <= granted port
//    - burst_cnt <= (granted == last_owner) ? sat_inc(burst_cnt) : 1
//    - last_owner <= granted port
//  - An idle cycle (no grant) clears burst_cnt to 0 and sets resp_owner to NONE. last_owner holds.
//  - Response: <port>_rvalid_o = 1 in the cycle after that port's grant, for both reads and writes.
//    <port>_rdata_o = ram_rdata_i when that port's rvalid is 1, otherwise 0. Only one rvalid is high per cycle.
//  - Throughput is 1 access/cycle. Back-to-back grants to different ports are legal, and their responses
//    also come back to back.
//  - A requester must hold req/addr/we/wdata stable until gnt. The arbiter never grants a port whose req=0.
//  - Reset asserted mid-access: any pending response is dropped (no rvalid after reset release), and the
//    state returns to reset values.
//  - burst_cnt saturates at MAX_BURST. It cannot wrap.
// STRUCTURE
//  - Package jedro_1_dmem_arb_pkg: typedef enum logic [1:0] {OWN_CORE, OWN_DBG, OWN_NONE} dmem_owner_e.
//    It also holds a localparam for the burst counter width, $clog2(MAX_BURST+1).
//  - State: last_owner, resp_owner (dmem_owner_e), burst_cnt.
//  - One always_ff with async reset, plus always_comb blocks for grant and mux.
//  - No sub-module needed.
// TESTING
//  - Reset: hold rstn_i=0 for 3 cycles with both req=1.
//    -> all gnt, rvalid and ram_en are 0; the first grant after release goes to core (last_owner=CORE).
//  - Single requester: core writes 0x0000000F to 0x10 (we=4'hF), then reads 0x10.
//    -> gnt in the same cycle each time; the read gives core_rvalid_o and core_rdata_o=0x0000000F one cycle
//    later; dbg_rvalid_o stays 0.
//  - Contention with MAX_BURST=4: both ports request continuously.
//    -> grant sequence is C,C,C,C,D,D,D,D,C...; each rvalid lands one cycle after its gnt.
//  - Alternation: dbg writes 0xDEADBEEF to 0x20, then core reads 0x20 in the very next cycle.
//    -> core_rdata_o = 0xDEADBEEF.
//  - Byte enables: dbg writes 0x000000AA with we=4'b0001 over a word holding 0x11223344.
//    -> a later read returns 0x112233AA.
//  - Reset mid-access: assert rstn_i in the cycle after a core read grant.
//    -> core_rvalid_o never pulses for that read; the next grant after release is correct.

Source files
------------

// File: rtl/jedro_1_dmem_arb_pkg.sv
// Shared types and sizing for the jedro_1 data-memory arbiter.
// Owner encoding is used both for the round-robin history and for routing responses.
package jedro_1_dmem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_CORE = 2'd0,
        OWN_DBG  = 2'd1,
        OWN_NONE = 2'd2
    } dmem_owner_e;

    localparam int unsigned DMEM_MAX_BURST   = 4;
    localparam int unsigned DMEM_BURST_CNT_W = $clog2(DMEM_MAX_BURST + 1);

endpackage

// File: rtl/jedro_1_dmem_arbiter.sv
// Round-robin arbiter sharing one single-port byte-write RAM between the core LSU and a debug master.
// Grants are combinational; responses return one cycle later to whichever port owned the access.
module jedro_1_dmem_arbiter
    import jedro_1_dmem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_BURST  = DMEM_MAX_BURST
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,

    input  logic                    core_req_i,
    input  logic [DATA_WIDTH/8-1:0] core_we_i,
    input  logic [ADDR_WIDTH-1:0]   core_addr_i,
    input  logic [DATA_WIDTH-1:0]   core_wdata_i,
    output logic                    core_gnt_o,
    output logic                    core_rvalid_o,
    output logic [DATA_WIDTH-1:0]   core_rdata_o,

    input  logic                    dbg_req_i,
    input  logic [DATA_WIDTH/8-1:0] dbg_we_i,
    input  logic [ADDR_WIDTH-1:0]   dbg_addr_i,
    input  logic [DATA_WIDTH-1:0]   dbg_wdata_i,
    output logic                    dbg_gnt_o,
    output logic                    dbg_rvalid_o,
    output logic [DATA_WIDTH-1:0]   dbg_rdata_o,

    output logic                    ram_en_o,
    output logic [DATA_WIDTH/8-1:0] ram_we_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    dmem_owner_e      last_owner;
    dmem_owner_e      resp_owner;
    dmem_owner_e      gnt_owner;
    logic [CNT_W-1:0] burst_cnt;
    logic             keep_last;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        if (cnt >= CNT_W'(MAX_BURST)) begin
            return CNT_W'(MAX_BURST);
        end
        return cnt + CNT_W'(1);
    endfunction

    // Nothing is granted while reset is held, even with requests pending.
    always_comb begin
        gnt_owner = OWN_NONE;
        keep_last = (burst_cnt < CNT_W'(MAX_BURST));
        if (rstn_i) begin
            if (core_req_i && dbg_req_i) begin
                if (keep_last) begin
                    gnt_owner = last_owner;
                end else begin
                    gnt_owner = (last_owner == OWN_CORE) ? OWN_DBG : OWN_CORE;
                end
            end else if (core_req_i) begin
                gnt_owner = OWN_CORE;
            end else if (dbg_req_i) begin
                gnt_owner = OWN_DBG;
            end
        end
    end

    always_comb begin
        core_gnt_o  = (gnt_owner == OWN_CORE);
        dbg_gnt_o   = (gnt_owner == OWN_DBG);
        ram_en_o    = (gnt_owner != OWN_NONE);
        ram_we_o    = '0;
        ram_addr_o  = core_addr_i;
        ram_wdata_o = core_wdata_i;
        if (gnt_owner == OWN_CORE) begin
            ram_we_o = core_we_i;
        end else if (gnt_owner == OWN_DBG) begin
            ram_we_o    = dbg_we_i;
            ram_addr_o  = dbg_addr_i;
            ram_wdata_o = dbg_wdata_i;
        end
    end

    // An idle cycle breaks any burst; last_owner keeps the round-robin history.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            last_owner <= OWN_CORE;
            resp_owner <= OWN_NONE;
            burst_cnt  <= '0;
        end else if (gnt_owner != OWN_NONE) begin
            resp_owner <= gnt_owner;
            burst_cnt  <= (gnt_owner == last_owner) ? sat_inc(burst_cnt) : CNT_W'(1);
            last_owner <= gnt_owner;
        end else begin
            resp_owner <= OWN_NONE;
            burst_cnt  <= '0;
        end
    end

    always_comb begin
        core_rvalid_o = (resp_owner == OWN_CORE);
        dbg_rvalid_o  = (resp_owner == OWN_DBG);
        core_rdata_o  = core_rvalid_o ? ram_rdata_i : '0;
        dbg_rdata_o   = dbg_rvalid_o ? ram_rdata_i : '0;
    end

    logic unused_be;
    assign unused_be = (BE_W == 0);

endmodule

// File: tb/tb_jedro_1_dmem_arbiter.sv
// Bench for the jedro_1 data-memory arbiter: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level model with its own reference memory.
module tb_jedro_1_dmem_arbiter;

    localparam int MAX_B = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        core_req = 1'b0;
    logic [3:0]  core_we = 4'h0;
    logic [31:0] core_addr = 32'h0;
    logic [31:0] core_wdata = 32'h0;
    logic        core_gnt, core_rvalid;
    logic [31:0] core_rdata;
    logic        dbg_req = 1'b0;
    logic [3:0]  dbg_we = 4'h0;
    logic [31:0] dbg_addr = 32'h0;
    logic [31:0] dbg_wdata = 32'h0;
    logic        dbg_gnt, dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [31:0] ram_addr, ram_wdata;
    logic [31:0] ram_rdata = 32'h0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    jedro_1_dmem_arbiter dut (
        .clk_i(clk), .rstn_i(rstn),
        .core_req_i(core_req), .core_we_i(core_we), .core_addr_i(core_addr),
        .core_wdata_i(core_wdata), .core_gnt_o(core_gnt), .core_rvalid_o(core_rvalid),
        .core_rdata_o(core_rdata),
        .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr),
        .dbg_wdata_i(dbg_wdata), .dbg_gnt_o(dbg_gnt), .dbg_rvalid_o(dbg_rvalid),
        .dbg_rdata_o(dbg_rdata),
        .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
        .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] we,
                                          input logic [31:0] wd);
        logic [31:0] w;
        w = old;
        for (int b = 0; b < 4; b++) if (we[b]) w[8*b +: 8] = wd[8*b +: 8];
        return w;
    endfunction

    // RAM environment: read-first, one-cycle read latency, driven by the DUT.
    logic [31:0] bram [int];
    always @(posedge clk) begin
        if (ram_en) begin
            ram_rdata <= bram.exists(int'(ram_addr >> 2)) ? bram[int'(ram_addr >> 2)] : 32'h0;
            bram[int'(ram_addr >> 2)] = merge(bram.exists(int'(ram_addr >> 2)) ?
                                              bram[int'(ram_addr >> 2)] : 32'h0, ram_we, ram_wdata);
        end
    end

    // Reference model: who is served, what the memory holds, and what each response returns.
    logic [31:0] refmem [int];
    int          m_last = 0;    // 0 core, 1 dbg
    int          m_burst = 0;
    int          m_resp = 2;    // 0 core, 1 dbg, 2 none
    logic [31:0] m_rdata = 0;
    int          g;
    int          idx;
    logic [3:0]  s_we;
    logic [31:0] s_addr, s_wdata, old;

    always @(negedge clk) begin
        if (!rstn) begin
            check("rst_gnt_en", {29'd0, core_gnt, dbg_gnt, ram_en}, 32'd0);
            check("rst_rvalid", {30'd0, core_rvalid, dbg_rvalid}, 32'd0);
            check("rst_rdata", core_rdata | dbg_rdata, 32'd0);
            m_last = 0; m_burst = 0; m_resp = 2;
        end else begin
            check("core_rvalid", {31'd0, core_rvalid}, {31'd0, m_resp == 0});
            check("dbg_rvalid", {31'd0, dbg_rvalid}, {31'd0, m_resp == 1});
            check("core_rdata", core_rdata, (m_resp == 0) ? m_rdata : 32'd0);
            check("dbg_rdata", dbg_rdata, (m_resp == 1) ? m_rdata : 32'd0);
            if (core_req && dbg_req) g = (m_burst < MAX_B) ? m_last : 1 - m_last;
            else if (core_req)       g = 0;
            else if (dbg_req)        g = 1;
            else                     g = 2;
            check("gnt", {30'd0, core_gnt, dbg_gnt}, {30'd0, g == 0, g == 1});
            check("ram_en", {31'd0, ram_en}, {31'd0, g != 2});
            if (g != 2) begin
                s_we    = (g == 0) ? core_we : dbg_we;
                s_addr  = (g == 0) ? core_addr : dbg_addr;
                s_wdata = (g == 0) ? core_wdata : dbg_wdata;
                check("ram_we", {28'd0, ram_we}, {28'd0, s_we});
                check("ram_addr", ram_addr, s_addr);
                if (s_we != 4'h0) check("ram_wdata", ram_wdata, s_wdata);
                idx = int'(s_addr >> 2);
                old = refmem.exists(idx) ? refmem[idx] : 32'h0;
                refmem[idx] = merge(old, s_we, s_wdata);
                m_rdata = old;
                if (g == m_last) m_burst = (m_burst < MAX_B) ? m_burst + 1 : MAX_B;
                else             m_burst = 1;
                m_last = g;
                m_resp = g;
            end else begin
                check("idle_we", {28'd0, ram_we}, 32'd0);
                m_burst = 0;
                m_resp = 2;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [11:0] exp_seq;
    logic        core_taken, dbg_taken;

    initial begin
        // Reset with both ports requesting.
        core_req = 1'b1; core_addr = 32'h40;
        dbg_req = 1'b1;  dbg_addr = 32'h44;
        repeat (3) begin
            @(negedge clk);
            check("lit_rst_quiet", {27'd0, core_gnt, dbg_gnt, core_rvalid, dbg_rvalid, ram_en}, 32'd0);
        end
        step(); rstn = 1'b1;
        @(negedge clk); check("lit_first_gnt_core", {30'd0, core_gnt, dbg_gnt}, 32'd2);
        step(); core_req = 1'b0;
        @(negedge clk); check("lit_dbg_only_gnt", {31'd0, dbg_gnt}, 32'd1);
        step(); dbg_req = 1'b0;

        // Core write then read of 0x10.
        core_req = 1'b1; core_we = 4'hF; core_addr = 32'h10; core_wdata = 32'h0000000F;
        @(negedge clk); check("lit_core_wr_gnt", {31'd0, core_gnt}, 32'd1);
        step(); core_we = 4'h0;
        @(negedge clk); check("lit_core_rd_gnt", {31'd0, core_gnt}, 32'd1);
        step(); core_req = 1'b0;
        @(negedge clk);
        check("lit_core_rd_rvalid", {31'd0, core_rvalid}, 32'd1);
        check("lit_core_rd_data", core_rdata, 32'h0000000F);
        check("lit_dbg_rvalid_low", {31'd0, dbg_rvalid}, 32'd0);
        step();

        // Continuous contention: bursts of four alternate between ports.
        core_req = 1'b1; core_we = 4'h0; core_addr = 32'h50;
        dbg_req = 1'b1;  dbg_we = 4'h0;  dbg_addr = 32'h54;
        exp_seq = 12'b0000_1111_0000;   // 1 = dbg, MSB first
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("lit_burst_seq", {30'd0, core_gnt, dbg_gnt}, {30'd0, ~exp_seq[11-i], exp_seq[11-i]});
            step();
        end
        core_req = 1'b0; dbg_req = 1'b0;
        step();

        // Dbg write immediately followed by a core read of the same word.
        dbg_req = 1'b1; dbg_we = 4'hF; dbg_addr = 32'h20; dbg_wdata = 32'hDEADBEEF;
        @(negedge clk); check("lit_dbg_wr_gnt", {31'd0, dbg_gnt}, 32'd1);
        step(); dbg_req = 1'b0; core_req = 1'b1; core_we = 4'h0; core_addr = 32'h20;
        @(negedge clk);
        check("lit_alt_core_gnt", {31'd0, core_gnt}, 32'd1);
        check("lit_alt_dbg_rvalid", {31'd0, dbg_rvalid}, 32'd1);
        step(); core_req = 1'b0;
        @(negedge clk); check("lit_alt_rdata", core_rdata, 32'hDEADBEEF);
        step();

        // Byte-enable merge.
        core_req = 1'b1; core_we = 4'hF; core_addr = 32'h30; core_wdata = 32'h11223344;
        step(); core_req = 1'b0;
        dbg_req = 1'b1; dbg_we = 4'b0001; dbg_addr = 32'h30; dbg_wdata = 32'h000000AA;
        step(); dbg_req = 1'b0;
        core_req = 1'b1; core_we = 4'h0; core_addr = 32'h30;
        step(); core_req = 1'b0;
        @(negedge clk); check("lit_byte_merge", core_rdata, 32'h112233AA);
        step();

        // Reset during the response cycle of a core read.
        dbg_req = 1'b1; dbg_we = 4'h0; dbg_addr = 32'h30;
        step(); dbg_req = 1'b0;
        core_req = 1'b1; core_addr = 32'h30;
        @(negedge clk); check("lit_pre_rst_gnt", {31'd0, core_gnt}, 32'd1);
        step(); core_req = 1'b0; rstn = 1'b0;
        @(negedge clk); check("lit_rst_drop", {31'd0, core_rvalid}, 32'd0);
        step(); step(); rstn = 1'b1;
        @(negedge clk); check("lit_no_rvalid_after_rst", {30'd0, core_rvalid, dbg_rvalid}, 32'd0);
        step(); core_req = 1'b1; dbg_req = 1'b1;
        @(negedge clk); check("lit_post_rst_gnt", {30'd0, core_gnt, dbg_gnt}, 32'd2);
        step(); core_req = 1'b0; dbg_req = 1'b0;
        step();

        // Randomized traffic; requests are held until granted.
        core_taken = 1'b0; dbg_taken = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (!core_req || core_taken) begin
                core_req   = ($urandom_range(0, 99) < 60);
                core_we    = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
                core_addr  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
                core_wdata = $urandom;
            end
            if (!dbg_req || dbg_taken) begin
                dbg_req   = ($urandom_range(0, 99) < 55);
                dbg_we    = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
                dbg_addr  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
                dbg_wdata = $urandom;
            end
            rstn = ($urandom_range(0, 299) != 0);
            @(negedge clk);
            core_taken = core_gnt;
            dbg_taken  = dbg_gnt;
            step();
        end
        rstn = 1'b1; core_req = 1'b0; dbg_req = 1'b0;
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
